qam_slicer_seq: RTL and testbench
=================================

# qam_slicer_seq

Sequencer for the 16-QAM hard-decision slicer in the receiver. It accepts equalised (I,Q) samples over a valid/ready handshake and generates the slicer's `start` enable. It shadows the slicer's two-stage pipeline with valid bits and captures decided symbols (x, y, phi) into a small output FIFO with downstream backpressure. It also marks frame boundaries for the symbol demapper.

## Interface
- `width_in`, default 18: sample width, signed.
- `width_out`, default 16: decided-point and phase width.
- `DEPTH`, default 4: output FIFO entries; power of two, minimum 2.
- `FRAME_LEN`, default 256: symbols per frame; minimum 1.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  run enable; a high level starts or continues a frame.
- `in_valid`  in  1  sample valid.
- `in_ready`  out  1  sample accepted when `in_valid & in_ready`.
- `x_in`, `y_in`  in  width_in  signed I and Q sample.
- `sl_x`, `sl_y`  out  width_in  to slicer `x_in`/`y_in`; combinational pass-through of `x_in`/`y_in`.
- `sl_start`  out  1  to slicer `start`.
- `sl_x_out`, `sl_y_out`, `sl_phi`  in  width_out  from slicer outputs.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  downstream pop.
- `x_out`, `y_out`, `phi_out`  out  width_out  FIFO head.
- `out_last`  out  1  head is the final symbol of a frame.
- `busy`  out  1  state is not IDLE.

## Operation
- Pipeline shadow bits:
  - `v1`/`v2` mirror slicer stages 1/2.
  - `l1`/`l2` carry the last-of-frame tag.
- `adv = (v2 == 0) | (fifo_cnt < DEPTH) | (out_valid & out_ready)`.
- `sl_start = adv & (state != IDLE)`.
- On `sl_start`:
  - `v1 <= in_valid & in_ready`, `v2 <= v1`; same shift for `l1`/`l2`.
  - If `v2` is set, push {`sl_x_out`, `sl_y_out`, `sl_phi`, `l2`} to the FIFO. The push uses the stage-2 data before it is overwritten.
- `in_ready = sl_start & (state == RUN)`.
- A `sl_start` cycle without an accept injects a bubble (`v1 <= 0`).
- State machine:
  - IDLE → RUN when `en = 1`; the frame counter clears.
  - RUN: each accept increments `fcnt`. The accept with `fcnt == FRAME_LEN-1` sets `l1` and moves the state to DRAIN.
  - RUN → DRAIN also when `en` falls mid-frame. That frame is truncated and no `out_last` is generated.
  - DRAIN: `in_ready = 0`; `sl_start` keeps advancing bubbles until `v1 = v2 = 0`, then the state moves to IDLE.
- FIFO behaviour:
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo `DEPTH`.
  - A push into a full FIFO cannot occur, because `adv` forbids it.
- Width rules:
  - `fcnt` is `$clog2(FRAME_LEN)` bits, minimum 1.
  - `fifo_cnt` is `$clog2(DEPTH)+1` bits.

## Timing
- Reset values:
  - All shadow bits, `fcnt`, the FIFO pointers and `fifo_cnt` are 0.
  - State is IDLE.
  - `in_ready`, `sl_start`, `out_valid`, `out_last` and `busy` are 0.
  - `x_out`, `y_out` and `phi_out` are 0.
  - `sl_x`/`sl_y` follow `x_in`/`y_in`.
- Latency with no backpressure: a sample accepted in cycle T is pushed in T+2 and shows `out_valid` in T+3.
- Backpressure: with the FIFO full and no pop, `sl_start = 0`. The slicer freezes and up to 2 symbols are held in the pipeline without loss.
- Throughput: 1 symbol per cycle while `out_ready` is high.
- Frame turnaround: DRAIN takes 2 `sl_start` cycles, plus 1 cycle to return to IDLE.
- Reset asserted mid-frame clears everything immediately. Symbols in flight are discarded.

## Configuration
- `QAM_SLICER_SEQ_STATS_EN`:
  - Defined: adds output `sym_cnt` [31:0], which increments on every pop, wraps at 2^32 and resets to 0.
  - Also adds output `ovf_seen` [0:0], a sticky flag set when `in_valid` is high in RUN while `in_ready` is 0. It clears only on reset.
  - Undefined: neither port exists and no related logic is present.

## Test plan
- Streaming: `FRAME_LEN = 4`, `en = 1`, `out_ready = 1`, samples (9000, 100), (-100, -9000), (100, 100), (-9000, 9000).
  - Outputs: (12288, 4096, 1318), (-4096, -12288, 17984), (4096, 4096, 3217), (-12288, 12288, 9651).
  - First `out_valid` 3 cycles after the first accept; `out_last` set on the 4th symbol; `busy` falls after DRAIN.
- Backpressure: `DEPTH = 4`, `out_ready = 0`, 8 samples offered.
  - Exactly 6 accepted (4 in the FIFO, 2 in the pipeline); `sl_start` stays 0.
  - Then `out_ready = 1`: all 6 emerge in order, followed by the remaining 2.
- Bubbles: alternate `in_valid` 1/0.
  - No duplicate or phantom symbols; output count equals the accept count.
- Truncated frame: `en` drops after 2 of 4 accepts.
  - 2 symbols are output with `out_last = 0`, `in_ready` goes to 0, and the state reaches IDLE.
- Simultaneous push/pop: with the FIFO at 3/4, push and pop in the same cycle.
  - `fifo_cnt` stays 3; order is preserved across pointer wrap.
- Reset mid-frame: assert `rst_n = 0` with 2 symbols in flight.
  - All outputs go to 0 asynchronously; after release, no stale symbols appear.

Source files
------------

// File: rtl/qam_slicer_seq.sv
// rtl/qam_slicer_seq.sv - sequencer, pipeline shadow and output FIFO for the 16-QAM slicer
// Optional QAM_SLICER_SEQ_STATS_EN adds sym_cnt and ovf_seen outputs.
module qam_slicer_seq #(
  parameter int width_in  = 18,
  parameter int width_out = 16,
  parameter int DEPTH     = 4,
  parameter int FRAME_LEN = 256
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [width_in-1:0]  x_in,
  input  logic signed [width_in-1:0]  y_in,
  output logic signed [width_in-1:0]  sl_x,
  output logic signed [width_in-1:0]  sl_y,
  output logic                        sl_start,
  input  logic signed [width_out-1:0] sl_x_out,
  input  logic signed [width_out-1:0] sl_y_out,
  input  logic signed [width_out-1:0] sl_phi,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [width_out-1:0] x_out,
  output logic signed [width_out-1:0] y_out,
  output logic signed [width_out-1:0] phi_out,
  output logic                        out_last,
  output logic                        busy
`ifdef QAM_SLICER_SEQ_STATS_EN
  ,
  output logic [31:0]                 sym_cnt,
  output logic                        ovf_seen
`endif
);

  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = 3 * width_out + 1;
  localparam logic [FW-1:0] FLAST  = FW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] CDEPTH = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state, state_nx;
  logic            v1, v2, l1, l2;
  logic [FW-1:0]   fcnt;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   fifo_cnt;
  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   head;
  logic            adv, accept, push, pop, last_acc;

  assign sl_x = x_in;
  assign sl_y = y_in;

  // The slicer only advances when stage 2 has somewhere to go.
  always_comb begin
    out_valid = (fifo_cnt != '0);
    pop       = out_valid & out_ready;
    adv       = ~v2 | (fifo_cnt < CDEPTH) | pop;
    sl_start  = adv & (state != IDLE);
    in_ready  = sl_start & (state == RUN);
    accept    = in_valid & in_ready;
    push      = sl_start & v2;
    last_acc  = accept & (fcnt == FLAST);
    busy      = (state != IDLE);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (en) state_nx = RUN;
      RUN:     if (last_acc || !en) state_nx = DRAIN;
      DRAIN:   if (!v1 && !v2) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      v1       <= 1'b0;
      v2       <= 1'b0;
      l1       <= 1'b0;
      l2       <= 1'b0;
      fcnt     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && en)
        fcnt <= '0;
      else if (accept)
        fcnt <= fcnt + 1'b1;
      if (sl_start) begin
        v1 <= accept;
        v2 <= v1;
        l1 <= last_acc;
        l2 <= l1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {sl_x_out, sl_y_out, sl_phi, l2};
  end

  always_comb begin
    head     = mem[rd_ptr];
    x_out    = out_valid ? head[3*width_out -: width_out] : '0;
    y_out    = out_valid ? head[2*width_out -: width_out] : '0;
    phi_out  = out_valid ? head[width_out -: width_out]   : '0;
    out_last = out_valid & head[0];
  end

`ifdef QAM_SLICER_SEQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_cnt  <= '0;
      ovf_seen <= 1'b0;
    end else begin
      if (pop) sym_cnt <= sym_cnt + 32'd1;
      if (in_valid && state == RUN && !in_ready) ovf_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_qam_slicer_seq.sv
// tb/tb_qam_slicer_seq.sv - self-checking bench for qam_slicer_seq with a behavioural slicer
module tb_qam_slicer_seq;
  localparam int WI = 18;
  localparam int WO = 16;
  localparam int DEPTH = 4;
  localparam int FLEN = 4;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic signed [WI-1:0] x_in = '0, y_in = '0, sl_x, sl_y;
  logic sl_start, in_ready, out_valid, out_last, busy;
  logic signed [WO-1:0] sl_x_out, sl_y_out, sl_phi, x_out, y_out, phi_out;
`ifdef QAM_SLICER_SEQ_STATS_EN
  logic [31:0] sym_cnt;
  logic ovf_seen;
`endif

  typedef struct {
    logic signed [WO-1:0] x, y, phi;
    logic last;
  } sym_t;

  typedef struct {
    logic signed [WI-1:0] xi, yi;
    logic signed [WO-1:0] ex, ey, ep;
    logic el;
  } vec_t;

  sym_t exp_q[$], got_q[$];
  sym_t st1, st2, mg, me;
  int total = 0, bad = 0;
  int n_acc = 0, n_out = 0, frame_pos = 0, cyc = 0;
  int first_acc_cyc = -1, first_ov_cyc = -1;

  always #5 clk = ~clk;

  qam_slicer_seq #(.width_in(WI), .width_out(WO), .DEPTH(DEPTH), .FRAME_LEN(FLEN)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .sl_x(sl_x), .sl_y(sl_y), .sl_start(sl_start),
    .sl_x_out(sl_x_out), .sl_y_out(sl_y_out), .sl_phi(sl_phi),
    .out_valid(out_valid), .out_ready(out_ready), .x_out(x_out), .y_out(y_out),
    .phi_out(phi_out), .out_last(out_last), .busy(busy)
`ifdef QAM_SLICER_SEQ_STATS_EN
    , .sym_cnt(sym_cnt), .ovf_seen(ovf_seen)
`endif
  );

  function automatic logic signed [WO-1:0] level(input logic signed [WI-1:0] v);
    if (v >= 0) return (v < 8192) ? 16'sd4096 : 16'sd12288;
    return (v >= -8192) ? -16'sd4096 : -16'sd12288;
  endfunction

  // Nearest 16-QAM point; phase in [0, 2*pi) scaled by 4096.
  function automatic sym_t decide(input logic signed [WI-1:0] xi, input logic signed [WI-1:0] yi);
    sym_t s;
    real a;
    s.x = level(xi);
    s.y = level(yi);
    a = $atan2(real'(s.y), real'(s.x));
    if (a < 0.0) a = a + 2.0 * 3.14159265358979;
    s.phi = WO'($rtoi(a * 4096.0 + 0.5));
    s.last = 1'b0;
    return s;
  endfunction

  // Two-stage slicer model driven by sl_start.
  always @(posedge clk) begin
    if (sl_start) begin
      st1 <= decide(sl_x, sl_y);
      st2 <= st1;
    end
  end
  assign sl_x_out = st2.x;
  assign sl_y_out = st2.y;
  assign sl_phi   = st2.phi;

  task automatic chk(input string name, input longint act, input longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Reference model: every accepted sample must come out once, in order, decided, with last on the FLEN-th of a frame.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        cyc++;
        if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
        if (out_valid && out_ready) begin
          mg = '{x_out, y_out, phi_out, out_last};
          got_q.push_back(mg);
          n_out++;
          if (exp_q.size() == 0) chk("phantom_symbol", 1, 0);
          else begin
            me = exp_q.pop_front();
            chk("out_x", x_out, me.x);
            chk("out_y", y_out, me.y);
            chk("out_phi", phi_out, me.phi);
            chk("out_last", out_last, me.last);
          end
        end
        if (in_valid && in_ready) begin
          if (first_acc_cyc < 0) first_acc_cyc = cyc;
          me = decide(x_in, y_in);
          frame_pos++;
          me.last = (frame_pos == FLEN);
          if (me.last) frame_pos = 0;
          exp_q.push_back(me);
          n_acc++;
          chk("sl_passthrough", {sl_x, sl_y}, {x_in, y_in});
        end
        if (!en) frame_pos = 0;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [WI-1:0] xv, input logic signed [WI-1:0] yv);
    int n;
    bit done;
    n = 0;
    done = 0;
    x_in = xv;
    y_in = yv;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1;
      else if (n++ > 100) begin
        chk("send_timeout", 0, 1);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain;
    int n;
    n = 0;
    en = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || busy || out_valid) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_timeout", n < 200, 1);
  endtask

  function automatic logic signed [WI-1:0] rnd_sample();
    return WI'(int'($urandom_range(0, 32767)) - 16384);
  endfunction

  initial begin
    vec_t tbl[4];
    logic signed [WI-1:0] bpx[8], bpy[8];
    int n, k, a0, o0;
    tbl[0] = '{18'sd9000,  18'sd100,   16'sd12288,  16'sd4096,   16'sd1318,  1'b0};
    tbl[1] = '{-18'sd100,  -18'sd9000, -16'sd4096,  -16'sd12288, 16'sd17984, 1'b0};
    tbl[2] = '{18'sd100,   18'sd100,   16'sd4096,   16'sd4096,   16'sd3217,  1'b0};
    tbl[3] = '{-18'sd9000, 18'sd9000,  -16'sd12288, 16'sd12288,  16'sd9651,  1'b1};

    // reset values
    repeat (3) @(posedge clk);
    #1;
    x_in = 18'sd1234;
    y_in = -18'sd77;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_sl_start", sl_start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_x_out", x_out, 0);
    chk("rst_y_out", y_out, 0);
    chk("rst_phi_out", phi_out, 0);
    chk("rst_sl_x", sl_x, 1234);
    chk("rst_sl_y", sl_y, -77);
    rst_n = 1'b1;
    tick();

    // streaming frame against the fixed table
    got_q.delete();
    first_acc_cyc = -1;
    first_ov_cyc = -1;
    en = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(tbl[i].xi, tbl[i].yi);
    en = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    chk("drain_cycles", n, 3);
    wait_drain();
    chk("stream_latency", first_ov_cyc - first_acc_cyc, 3);
    chk("stream_count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      chk("tbl_x", got_q[i].x, tbl[i].ex);
      chk("tbl_y", got_q[i].y, tbl[i].ey);
      chk("tbl_phi", got_q[i].phi, tbl[i].ep);
      chk("tbl_last", got_q[i].last, tbl[i].el);
    end

    // simultaneous push and pop with the FIFO at 3 of 4
    en = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(rnd_sample(), rnd_sample());
    n = 0;
    while (dut.fifo_cnt != 3 && n < 20) begin
      tick();
      n++;
    end
    chk("fill_to_3", dut.fifo_cnt, 3);
    out_ready = 1'b1;
    tick();
    chk("pushpop_cnt", dut.fifo_cnt, 3);
    wait_drain();

    // backpressure: FIFO full plus two held in the pipeline
    for (int i = 0; i < 8; i++) begin
      bpx[i] = rnd_sample();
      bpy[i] = rnd_sample();
    end
    a0 = n_acc;
    k = 0;
    en = 1'b1;
    out_ready = 1'b0;
    x_in = bpx[0];
    y_in = bpy[0];
    in_valid = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (in_valid && in_ready) k++;
      tick();
      if (k < 8) begin
        x_in = bpx[k];
        y_in = bpy[k];
      end else in_valid = 1'b0;
    end
    chk("bp_accepts", n_acc - a0, 6);
    @(negedge clk);
    chk("bp_sl_start", sl_start, 0);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    tick();
    out_ready = 1'b1;
    n = 0;
    while (k < 8 && n < 100) begin
      @(negedge clk);
      if (in_valid && in_ready) k++;
      tick();
      n++;
      if (k < 8) begin
        x_in = bpx[k];
        y_in = bpy[k];
      end else in_valid = 1'b0;
    end
    chk("bp_all_accepted", k, 8);
    wait_drain();

    // truncated frame: en falls after 2 of 4
    got_q.delete();
    a0 = n_acc;
    o0 = n_out;
    en = 1'b1;
    send(rnd_sample(), rnd_sample());
    send(rnd_sample(), rnd_sample());
    en = 1'b0;
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    repeat (8) tick();
    in_valid = 1'b0;
    chk("trunc_accepts", n_acc - a0, 2);
    chk("trunc_idle", busy, 0);
    wait_drain();
    chk("trunc_outputs", n_out - o0, 2);
    if (got_q.size() == 2) chk("trunc_no_last", got_q[0].last | got_q[1].last, 0);
    else chk("trunc_got", got_q.size(), 2);

    // alternating bubbles
    a0 = n_acc;
    o0 = n_out;
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = (i % 2 == 0);
      x_in = rnd_sample();
      y_in = rnd_sample();
      tick();
    end
    wait_drain();
    chk("bub_some", (n_acc - a0) > 0, 1);
    chk("bub_count", n_out - o0, n_acc - a0);

    // random traffic with occasional en drops and backpressure
    a0 = n_acc;
    o0 = n_out;
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom % 4) != 0;
      x_in = rnd_sample();
      y_in = rnd_sample();
      out_ready = ($urandom % 3) != 0;
      en = ($urandom % 40) != 0;
      tick();
    end
    wait_drain();
    chk("rand_count", n_out - o0, n_acc - a0);

    // reset with two symbols in flight
    en = 1'b1;
    out_ready = 1'b1;
    send(rnd_sample(), rnd_sample());
    send(rnd_sample(), rnd_sample());
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_sl_start", sl_start, 0);
    chk("mrst_out_last", out_last, 0);
    chk("mrst_x_out", x_out, 0);
    exp_q.delete();
    frame_pos = 0;
    o0 = n_out;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("mrst_no_stale", n_out - o0, 0);
    chk("mrst_idle_valid", out_valid, 0);
`ifdef QAM_SLICER_SEQ_STATS_EN
    chk("stats_sym_cnt", sym_cnt, n_out - o0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
